morse_tx_sequencer: RTL and testbench

MORSE_TX_SEQUENCER -- requirements
Module: morse_tx_sequencer

---
 rtl/morse_tx_sequencer.sv | 176 +++++++++++++++++
 tb/tb_morse_tx_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : morse_tx_sequencer
//  Purpose  : Plays one Morse character from a left-aligned unit pattern.
//             Each pattern bit keys the tone for UNIT_DIV clock cycles. A
//             silent gap of GAP_UNITS units follows, and then a one-cycle
//             done pulse. A character can be cancelled with abort.
//  Ports    : CLK      - clock, all state changes on the rising edge
//             RST      - synchronous active-low reset
//             start    - transmit request, accepted only while ready=1
//             abort    - cancel the character in progress
//             patron   - 27-bit unit pattern, MSB first (bit 26 goes out first)
//             longitud - number of units to send, clamped to 27
//             key      - registered tone enable
//             ready    - idle and able to accept start
//             busy     - sending a pattern or its trailing gap
//             done     - one-cycle pulse after a normally completed character
//  Revision : 1.0 - initial release
// ============================================================================
module morse_tx_sequencer #(
   parameter int unsigned UNIT_DIV  = 25_000_000,
   parameter int unsigned GAP_UNITS = 3
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic        abort,
   input  logic [26:0] patron,
   input  logic [4:0]  longitud,
   output logic        key,
   output logic        ready,
   output logic        busy,
   output logic        done
);

   localparam logic [24:0] c_unit_last = 25'(UNIT_DIV - 1);
   localparam logic [2:0]  c_gap_last  = 3'(GAP_UNITS - 1);
   localparam logic [4:0]  c_max_len   = 5'd27;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t      r_state,     w_state_nxt;
   logic [26:0] r_shadow,    w_shadow_nxt;
   logic [4:0]  r_remaining, w_remaining_nxt;
   logic [24:0] r_count,     w_count_nxt;
   logic [2:0]  r_gap_cnt,   w_gap_cnt_nxt;
   logic        r_key,       w_key_nxt;
   logic        r_done,      w_done_nxt;

   logic        w_unit_wrap;
   logic [4:0]  w_len_clamped;

   assign w_unit_wrap   = (r_count == c_unit_last);
   assign w_len_clamped = (longitud > c_max_len) ? c_max_len : longitud;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state     <= ST_IDLE;
         r_shadow    <= '0;
         r_remaining <= '0;
         r_count     <= '0;
         r_gap_cnt   <= '0;
         r_key       <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_shadow    <= w_shadow_nxt;
         r_remaining <= w_remaining_nxt;
         r_count     <= w_count_nxt;
         r_gap_cnt   <= w_gap_cnt_nxt;
         r_key       <= w_key_nxt;
         r_done      <= w_done_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic. The key is registered, so the value computed here is
   // the level the key takes during the following cycle: on capture it is
   // the first pattern bit, and on a unit wrap it is the bit that is about
   // to move into position 26.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt     = r_state;
      w_shadow_nxt    = r_shadow;
      w_remaining_nxt = r_remaining;
      w_count_nxt     = r_count;
      w_gap_cnt_nxt   = r_gap_cnt;
      w_key_nxt       = 1'b0;
      w_done_nxt      = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (start && !abort) begin
               w_shadow_nxt    = patron;
               w_remaining_nxt = w_len_clamped;
               w_count_nxt     = '0;
               w_gap_cnt_nxt   = '0;
               if (w_len_clamped != 5'd0) begin
                  w_state_nxt = ST_SEND;
                  w_key_nxt   = patron[26];
               end else begin
                  w_state_nxt = ST_GAP;
               end
            end
         end

         ST_SEND: begin
            if (abort) begin
               w_state_nxt     = ST_IDLE;
               w_shadow_nxt    = '0;
               w_remaining_nxt = '0;
               w_count_nxt     = '0;
               w_gap_cnt_nxt   = '0;
            end else if (w_unit_wrap) begin
               w_count_nxt     = '0;
               w_shadow_nxt    = {r_shadow[25:0], 1'b0};
               w_remaining_nxt = r_remaining - 5'd1;
               if (r_remaining == 5'd1) begin
                  w_state_nxt   = ST_GAP;
                  w_gap_cnt_nxt = '0;
               end else begin
                  w_key_nxt = r_shadow[25];
               end
            end else begin
               w_count_nxt = r_count + 25'd1;
               w_key_nxt   = r_shadow[26];
            end
         end

         ST_GAP: begin
            // The gap length is counted in whole units. This keeps the unit
            // counter at 25 bits even when GAP_UNITS*UNIT_DIV would overflow it.
            if (abort) begin
               w_state_nxt     = ST_IDLE;
               w_shadow_nxt    = '0;
               w_remaining_nxt = '0;
               w_count_nxt     = '0;
               w_gap_cnt_nxt   = '0;
            end else if (w_unit_wrap) begin
               w_count_nxt = '0;
               if (r_gap_cnt == c_gap_last) begin
                  w_state_nxt   = ST_IDLE;
                  w_gap_cnt_nxt = '0;
                  w_done_nxt    = 1'b1;
               end else begin
                  w_gap_cnt_nxt = r_gap_cnt + 3'd1;
               end
            end else begin
               w_count_nxt = r_count + 25'd1;
            end
         end

         default: begin
            w_state_nxt     = ST_IDLE;
            w_shadow_nxt    = '0;
            w_remaining_nxt = '0;
            w_count_nxt     = '0;
            w_gap_cnt_nxt   = '0;
         end
      endcase
   end

   assign key   = r_key;
   assign done  = r_done;
   assign ready = (r_state == ST_IDLE);
   assign busy  = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_morse_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_morse_tx_sequencer
//  Purpose  : Self-checking bench for morse_tx_sequencer with UNIT_DIV=4 and
//             GAP_UNITS=3. Expected waveforms are derived from the character
//             timing rules: units*UNIT_DIV key cycles, then the gap, then done.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_morse_tx_sequencer;

   localparam int UD = 4;
   localparam int GU = 3;

   logic        CLK;
   logic        RST;
   logic        start;
   logic        abort;
   logic [26:0] patron;
   logic [4:0]  longitud;
   logic        key;
   logic        ready;
   logic        busy;
   logic        done;

   int n_checks;
   int n_fail;

   morse_tx_sequencer #(.UNIT_DIV(UD), .GAP_UNITS(GU)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .start    (start),
      .abort    (abort),
      .patron   (patron),
      .longitud (longitud),
      .key      (key),
      .ready    (ready),
      .busy     (busy),
      .done     (done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Drive the request at a falling edge; the next rising edge is edge 0.
   task automatic launch(input logic [26:0] pat, input logic [4:0] len);
      @(negedge CLK);
      patron   = pat;
      longitud = len;
      start    = 1'b1;
   endtask

   // Waits for edge 0, then checks cycles 1..end_of_gap+1 (the done cycle).
   // At cycle 10 the inputs are changed to np/nl, which must not affect the
   // character already captured. With keep=1, start stays high so that the
   // done-cycle edge recaptures.
   task automatic expect_char(input logic [26:0] pat, input logic [4:0] len,
                              input logic [26:0] np, input logic [4:0] nl,
                              input bit keep);
      int   units;
      int   total;
      int   idx;
      logic exp_key;
      logic [2:0] exp_st;
      units = (len > 5'd27) ? 27 : int'(len);
      total = units * UD + GU * UD;
      @(posedge CLK);
      for (int c = 1; c <= total + 1; c++) begin
         @(negedge CLK);
         if (c == 1) start = keep;
         if (c == 10) begin
            patron   = np;
            longitud = nl;
         end
         if (c <= units * UD) begin
            idx     = 26 - (c - 1) / UD;
            exp_key = pat[idx];
         end else begin
            exp_key = 1'b0;
         end
         exp_st = (c <= total) ? 3'b010 : 3'b101;
         n_checks++;
         if (key !== exp_key) begin
            n_fail++;
            $display("FAIL char_key len=%0d cycle=%0d actual=%b required=%b", len, c, key, exp_key);
         end
         n_checks++;
         if ({ready, busy, done} !== exp_st) begin
            n_fail++;
            $display("FAIL char_status len=%0d cycle=%0d actual rdy/bsy/done=%b required=%b",
                     len, c, {ready, busy, done}, exp_st);
         end
      end
   endtask

   task automatic expect_idle(input string name, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge CLK);
         n_checks++;
         if ({key, ready, busy, done} !== 4'b0100) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual key/rdy/bsy/done=%b required=0100",
                     name, c, {key, ready, busy, done});
         end
      end
   endtask

   task automatic test_reset;
      RST      = 1'b0;
      start    = 1'b1;
      abort    = 1'b0;
      patron   = '1;
      longitud = 5'd3;
      expect_idle("reset_hold", 4);
      // The first edge with RST=1 accepts the pending start.
      RST = 1'b1;
      expect_char('1, 5'd3, 27'h0, 5'd0, 1'b0);
      expect_idle("after_reset_char", 2);
   endtask

   task automatic test_char_a;
      logic [26:0] pa;
      pa = {5'b10111, 22'd0};
      launch(pa, 5'd5);
      expect_char(pa, 5'd5, 27'($urandom), 5'($urandom), 1'b0);
      expect_idle("after_a", 2);
   endtask

   task automatic test_zero_len;
      launch('1, 5'd0);
      expect_char('1, 5'd0, 27'($urandom), 5'($urandom), 1'b0);
      expect_idle("after_zero", 2);
   endtask

   task automatic test_clamp;
      launch('1, 5'd31);
      expect_char('1, 5'd31, 27'($urandom), 5'($urandom), 1'b0);
      launch(27'h5A5A5A5, 5'd28);
      expect_char(27'h5A5A5A5, 5'd28, 27'($urandom), 5'($urandom), 1'b0);
      expect_idle("after_clamp", 2);
   endtask

   task automatic test_abort;
      logic [26:0] pa;
      pa = {5'b10111, 22'd0};
      // Abort sampled at edge 6 during SEND.
      launch(pa, 5'd5);
      @(posedge CLK);
      for (int c = 1; c <= 6; c++) begin
         @(negedge CLK);
         if (c == 1) start = 1'b0;
         n_checks++;
         if (key !== pa[26 - (c - 1) / UD]) begin
            n_fail++;
            $display("FAIL abort_pre_key cycle=%0d actual=%b required=%b", c, key, pa[26 - (c - 1) / UD]);
         end
      end
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      n_checks++;
      if ({key, ready, busy, done} !== 4'b0100) begin
         n_fail++;
         $display("FAIL abort_send actual key/rdy/bsy/done=%b required=0100", {key, ready, busy, done});
      end
      expect_idle("abort_send_no_done", 40);
      // Abort during GAP of a zero-length character.
      launch('1, 5'd0);
      @(posedge CLK);
      @(negedge CLK);
      start = 1'b0;
      repeat (4) @(negedge CLK);
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      expect_idle("abort_gap", 20);
      // start and abort together in IDLE: abort wins.
      @(negedge CLK);
      start = 1'b1;
      abort = 1'b1;
      expect_idle("abort_wins_idle", 3);
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [26:0] pa;
      logic [26:0] p2;
      logic [4:0]  l2;
      pa = {5'b10111, 22'd0};
      p2 = 27'($urandom) | 27'h4000000;
      l2 = 5'($urandom_range(1, 8));
      launch(pa, 5'd5);
      expect_char(pa, 5'd5, p2, l2, 1'b1);
      expect_char(p2, l2, 27'($urandom), 5'($urandom), 1'b0);
      expect_idle("after_b2b", 2);
   endtask

   task automatic test_reset_mid;
      logic [26:0] pa;
      logic [26:0] pr;
      logic [4:0]  lr;
      pa = {5'b10111, 22'd0};
      launch(pa, 5'd5);
      @(posedge CLK);
      for (int c = 1; c <= 11; c++) begin
         @(negedge CLK);
         if (c == 1) start = 1'b0;
         n_checks++;
         if (key !== pa[26 - (c - 1) / UD]) begin
            n_fail++;
            $display("FAIL rst_mid_pre_key cycle=%0d actual=%b required=%b", c, key, pa[26 - (c - 1) / UD]);
         end
      end
      @(negedge CLK);
      RST = 1'b0;
      expect_idle("rst_mid", 2);
      RST = 1'b1;
      expect_idle("rst_release", 1);
      pr = 27'($urandom);
      lr = 5'($urandom_range(0, 6));
      launch(pr, lr);
      expect_char(pr, lr, 27'($urandom), 5'($urandom), 1'b0);
   endtask

   task automatic test_random;
      logic [26:0] pr;
      logic [4:0]  lr;
      for (int i = 0; i < 20; i++) begin
         pr = 27'($urandom);
         lr = 5'($urandom);
         launch(pr, lr);
         expect_char(pr, lr, 27'($urandom), 5'($urandom), 1'b0);
         if ($urandom_range(0, 1) == 1) expect_idle("random_idle", 1);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset;
      test_char_a;
      test_zero_len;
      test_clamp;
      test_abort;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
